// File: rtl/manchester_deframer.sv
// -----------------------------------------------------------------------------
// manchester_deframer
//
// Assembles the 0-2 bits per cycle produced by manchester_decoder2 into bytes,
// hunts for a sync byte, reads a length byte and streams the payload out as an
// 8-bit AXI-Stream with tlast on the final byte. Per-frame status pulses report
// clean completion or abort.
//
// Optional feature: define MANCHESTER_DEFRAMER_CRC_EN to append a CRC-8 check
// byte (poly 0x07, init 0x00, MSB-first) covering the length and payload bytes.
//
// Parameters
//   SYNC_WORD         sync byte marking frame start (MSB first)
//   IDLE_TIMEOUT      max consecutive bit-less cycles inside a frame (1..65535)
//
// Ports
//   aclk              receiver clock (same domain as the decoder)
//   aresetn           asynchronous active-low reset
//   decoded_bits      decoded bits; with two bits, [1] is older than [0]
//   num_decoded_bits  number of valid bits (0..2; 3 is treated as idle)
//   m_axis_tdata      payload byte
//   m_axis_tvalid     payload byte valid
//   m_axis_tready     downstream accept
//   m_axis_tlast      final payload byte of the frame
//   frame_done        1-cycle pulse: frame completed cleanly
//   frame_err         1-cycle pulse: frame aborted (overrun, timeout, CRC)
//   overrun           sticky: a byte was lost to backpressure
// -----------------------------------------------------------------------------
module manchester_deframer #(
  parameter logic [7:0]  SYNC_WORD    = 8'hD5,
  parameter int unsigned IDLE_TIMEOUT = 64
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic [1:0] decoded_bits,
  input  logic [1:0] num_decoded_bits,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       m_axis_tlast,
  output logic       frame_done,
  output logic       frame_err,
  output logic       overrun
);

`ifdef MANCHESTER_DEFRAMER_CRC_EN
  typedef enum logic [1:0] {HUNT, LEN, PAYLOAD, CRC} state_t;
`else
  typedef enum logic [1:0] {HUNT, LEN, PAYLOAD} state_t;
`endif

  state_t      state_q, state_d;
  logic [7:0]  sr_q, sr_d, sr_nxt;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  remaining_q, remaining_d;
  logic [15:0] idle_q, idle_d;
  logic [1:0]  slot_vld, slot_bit;   // slot 0 is the older bit
  logic        byte_end;
  logic        byte_evt, byte_last;
  logic [7:0]  byte_data;
  logic        done_evt, err_evt, ovr_evt;
  logic [7:0]  tdata_d;
  logic        tvalid_d, tlast_d;

`ifdef MANCHESTER_DEFRAMER_CRC_EN
  logic [7:0] crc_q, crc_d;

  function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic b);
    crc8_step = {c[6:0], 1'b0} ^ ((c[7] ^ b) ? 8'h07 : 8'h00);
  endfunction
`endif

  // Re-order the input into time order; num=3 yields no valid slot.
  always_comb begin
    slot_vld = 2'b00;
    slot_bit = 2'b00;
    case (num_decoded_bits)
      2'd1: begin
        slot_vld    = 2'b01;
        slot_bit[0] = decoded_bits[0];
      end
      2'd2: begin
        slot_vld    = 2'b11;
        slot_bit[0] = decoded_bits[1];
        slot_bit[1] = decoded_bits[0];
      end
      default: ;
    endcase
  end

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_q <= HUNT;
    else          state_q <= state_d;
  end

  // Next-state: walk the (up to two) bits in arrival order so sync matching
  // and byte boundaries are evaluated after each individual bit.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch is
    // inferred when a path leaves it unassigned.
    state_d     = state_q;
    sr_d        = sr_q;
    sr_nxt      = sr_q;
    bit_cnt_d   = bit_cnt_q;
    remaining_d = remaining_q;
    idle_d      = 16'd0;
    byte_end    = 1'b0;
    byte_evt    = 1'b0;
    byte_last   = 1'b0;
    byte_data   = 8'h00;
    done_evt    = 1'b0;
    err_evt     = 1'b0;
    ovr_evt     = 1'b0;
`ifdef MANCHESTER_DEFRAMER_CRC_EN
    crc_d       = crc_q;
`endif
    for (int i = 0; i < 2; i++) begin
      if (slot_vld[i[0]]) begin
        // NOTE: blocking assignments are intentional here: the second bit must
        // see the state, shift register and counters left by the first bit.
        sr_nxt = {sr_d[6:0], slot_bit[i[0]]};
        sr_d   = sr_nxt;
        if (state_d == HUNT) begin
          if (sr_nxt == SYNC_WORD) begin
            state_d   = LEN;
            bit_cnt_d = 3'd0;
`ifdef MANCHESTER_DEFRAMER_CRC_EN
            crc_d     = 8'h00;
`endif
          end
        end else begin
          byte_end  = (bit_cnt_d == 3'd7);
          bit_cnt_d = bit_cnt_d + 3'd1;   // wraps 7 -> 0 on byte completion
`ifdef MANCHESTER_DEFRAMER_CRC_EN
          if (state_d != CRC) crc_d = crc8_step(crc_d, slot_bit[i[0]]);
`endif
          if (byte_end) begin
            case (state_d)
              LEN: begin
                if (sr_nxt == 8'h00) begin
`ifdef MANCHESTER_DEFRAMER_CRC_EN
                  state_d  = CRC;
`else
                  state_d  = HUNT;
                  done_evt = 1'b1;
`endif
                end else begin
                  remaining_d = sr_nxt;
                  state_d     = PAYLOAD;
                end
              end
              PAYLOAD: begin
                // Only the registered tvalid matters: a handshake this cycle
                // frees the slot for the new byte.
                if (m_axis_tvalid && !m_axis_tready) begin
                  ovr_evt = 1'b1;
                  err_evt = 1'b1;
                  state_d = HUNT;
                end else begin
                  byte_evt    = 1'b1;
                  byte_data   = sr_nxt;
                  byte_last   = (remaining_d == 8'd1);
                  remaining_d = remaining_d - 8'd1;
                  if (byte_last) begin
`ifdef MANCHESTER_DEFRAMER_CRC_EN
                    state_d  = CRC;
`else
                    state_d  = HUNT;
                    done_evt = 1'b1;
`endif
                  end
                end
              end
`ifdef MANCHESTER_DEFRAMER_CRC_EN
              CRC: begin
                if (sr_nxt == crc_d) done_evt = 1'b1;
                else                 err_evt  = 1'b1;
                state_d = HUNT;
              end
`endif
              default: state_d = HUNT;
            endcase
          end
        end
      end
    end

    // Idle timeout: only bit-less cycles inside a frame count, so a bit that
    // arrives on the threshold cycle always wins.
    if (slot_vld == 2'b00 && state_q != HUNT) begin
      if (idle_q == 16'(IDLE_TIMEOUT - 1)) begin
        err_evt = 1'b1;
        state_d = HUNT;
      end else begin
        idle_d = idle_q + 16'd1;
      end
    end
  end

  // Output register: a new byte has priority over the handshake that frees it.
  always_comb begin
    tdata_d  = m_axis_tdata;
    tlast_d  = m_axis_tlast;
    tvalid_d = m_axis_tvalid;
    if (byte_evt) begin
      tdata_d  = byte_data;
      tlast_d  = byte_last;
      tvalid_d = 1'b1;
    end else if (m_axis_tvalid && m_axis_tready) begin
      tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sr_q          <= 8'h00;
      bit_cnt_q     <= 3'd0;
      remaining_q   <= 8'h00;
      idle_q        <= 16'd0;
      m_axis_tdata  <= 8'h00;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      frame_done    <= 1'b0;
      frame_err     <= 1'b0;
      overrun       <= 1'b0;
`ifdef MANCHESTER_DEFRAMER_CRC_EN
      crc_q         <= 8'h00;
`endif
    end else begin
      sr_q          <= sr_d;
      bit_cnt_q     <= bit_cnt_d;
      remaining_q   <= remaining_d;
      idle_q        <= idle_d;
      m_axis_tdata  <= tdata_d;
      m_axis_tvalid <= tvalid_d;
      m_axis_tlast  <= tlast_d;
      frame_done    <= done_evt;
      frame_err     <= err_evt;
      overrun       <= overrun | ovr_evt;
`ifdef MANCHESTER_DEFRAMER_CRC_EN
      crc_q         <= crc_d;
`endif
    end
  end

endmodule

// File: tb/tb_manchester_deframer.sv
// -----------------------------------------------------------------------------
// tb_manchester_deframer
//
// Directed and randomized bench for manchester_deframer. Frames are built as
// bit streams; expected payload beats and per-frame status are kept at frame
// level and compared against what the DUT presents. IDLE_TIMEOUT is set to 8.
// -----------------------------------------------------------------------------
module tb_manchester_deframer;

  localparam int IDLE_TO = 8;

  logic       aclk = 1'b0;
  logic       aresetn;
  logic [1:0] decoded_bits;
  logic [1:0] num_decoded_bits;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready;
  logic       m_axis_tlast;
  logic       frame_done;
  logic       frame_err;
  logic       overrun;

  always #5 aclk = ~aclk;

  manchester_deframer #(
    .SYNC_WORD   (8'hD5),
    .IDLE_TIMEOUT(IDLE_TO)
  ) dut (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .decoded_bits    (decoded_bits),
    .num_decoded_bits(num_decoded_bits),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tready   (m_axis_tready),
    .m_axis_tlast    (m_axis_tlast),
    .frame_done      (frame_done),
    .frame_err       (frame_err),
    .overrun         (overrun)
  );

  typedef struct {
    logic [7:0] data;
    logic       last;
  } beat_t;
  typedef logic [7:0] byte_q_t[$];

  beat_t exp_q[$];
  bit    bit_q[$];
  int    errors = 0, checks = 0;
  int    done_seen = 0, err_seen = 0, exp_done = 0, exp_err = 0;
  int    idle_run = 0;
  logic  s_tvalid, s_tlast, s_done, s_err, s_ovr;
  logic [7:0] s_tdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference CRC-8 (poly 0x07, init 0) over whole bytes.
  function automatic logic [7:0] crc8(input byte_q_t bytes);
    logic [7:0] c;
    c = 8'h00;
    foreach (bytes[i]) begin
      c = c ^ bytes[i];
      for (int k = 0; k < 8; k++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  // One clock: sample outputs at the falling edge, then drive the next inputs.
  task automatic step(input logic [1:0] n, input logic [1:0] d, input logic rdy);
    beat_t b;
    @(negedge aclk);
    s_tvalid = m_axis_tvalid;
    s_tdata  = m_axis_tdata;
    s_tlast  = m_axis_tlast;
    s_done   = frame_done;
    s_err    = frame_err;
    s_ovr    = overrun;
    if (s_done) done_seen++;
    if (s_err)  err_seen++;
    num_decoded_bits = n;
    decoded_bits     = d;
    m_axis_tready    = rdy;
    if (s_tvalid && rdy) begin
      check("beat_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        b = exp_q.pop_front();
        check("beat_data", s_tdata, b.data);
        check("beat_last", s_tlast, b.last);
      end
    end
  endtask

  task automatic idle(input int cycles, input logic rdy);
    repeat (cycles) step(2'd0, 2'd0, rdy);
  endtask

  task automatic push_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) bit_q.push_back(v[i]);
  endtask

  // Leading zeros guarantee no false sync from leftover shift-register bits.
  task automatic push_frame_bits(input byte_q_t pl, input int zeros, input logic bad_crc);
    byte_q_t all;
    repeat (zeros) bit_q.push_back(1'b0);
    push_byte(8'hD5);
    all.push_back(8'(pl.size()));
    foreach (pl[i]) all.push_back(pl[i]);
    foreach (all[i]) push_byte(all[i]);
`ifdef MANCHESTER_DEFRAMER_CRC_EN
    push_byte(crc8(all) ^ {7'd0, bad_crc});
`else
    if (bad_crc) push_byte(crc8(all));
`endif
  endtask

  task automatic queue_frame(input byte_q_t pl, input int zeros);
    push_frame_bits(pl, zeros, 1'b0);
    foreach (pl[i]) exp_q.push_back('{data: pl[i], last: (i == pl.size() - 1)});
    exp_done++;
  endtask

  // mode 1/2: fixed bits per cycle; mode 0: random 0..3 with idle runs kept
  // below the timeout threshold.
  task automatic send_bits(input int mode, input logic rdy, input int limit = 1 << 30);
    int n, sent;
    logic [1:0] d;
    sent = 0;
    while (bit_q.size() > 0 && sent < limit) begin
      if (mode == 0) begin
        n = int'($urandom_range(3, 0));
        if ((n == 0 || n == 3) && idle_run >= IDLE_TO - 1) n = 1 + int'($urandom_range(1, 0));
      end else begin
        n = mode;
      end
      if (n == 2 && (bit_q.size() < 2 || limit - sent < 2)) n = 1;
      d = 2'($urandom);
      if (n == 1) begin
        d[0] = bit_q.pop_front();
      end else if (n == 2) begin
        d[1] = bit_q.pop_front();
        d[0] = bit_q.pop_front();
      end
      if (n == 1 || n == 2) begin
        idle_run = 0;
        sent += n;
      end else begin
        idle_run++;
      end
      step(2'(n), d, rdy);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    byte_q_t pl;
    int len;

    aresetn          = 1'b0;
    decoded_bits     = 2'd0;
    num_decoded_bits = 2'd0;
    m_axis_tready    = 1'b0;

    // Reset values
    repeat (2) @(negedge aclk);
    check("rst_tdata",  m_axis_tdata,  0);
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tlast",  m_axis_tlast,  0);
    check("rst_done",   frame_done,    0);
    check("rst_err",    frame_err,     0);
    check("rst_ovr",    overrun,       0);
    aresetn = 1'b1;

    // Basic frame, one bit per cycle
    pl = '{8'hA1, 8'hB2, 8'hC3};
    queue_frame(pl, 8);
    send_bits(1, 1'b1);
    step(2'd0, 2'd0, 1'b1);
    check("basic_done_latency", s_done, 1);
    idle(3, 1'b1);
    check("basic_beats_left", exp_q.size(), 0);
    check("basic_done_count", done_seen, exp_done);
    check("basic_err_count",  err_seen,  exp_err);

    // Odd alignment, two bits per cycle
    pl = '{8'h11, 8'h22, 8'h33};
    queue_frame(pl, 9);
    send_bits(2, 1'b1);
    step(2'd0, 2'd0, 1'b1);
    check("odd_done_latency", s_done, 1);
    idle(3, 1'b1);
    check("odd_beats_left", exp_q.size(), 0);
    check("odd_done_count", done_seen, exp_done);

    // Zero-length frame
    pl = {};
    queue_frame(pl, 8);
    send_bits(1, 1'b1);
    step(2'd0, 2'd0, 1'b1);
    check("len0_done_latency", s_done, 1);
    check("len0_no_beat", s_tvalid, 0);
    idle(2, 1'b1);

    // Backpressure: hold first byte for 3 cycles, no overrun
    pl = '{8'h5A, 8'h3C};
    push_frame_bits(pl, 8, 1'b0);
    exp_q.push_back('{data: 8'h5A, last: 1'b0});
    exp_q.push_back('{data: 8'h3C, last: 1'b1});
    exp_done++;
    send_bits(1, 1'b0, 32);
    check("bp_tvalid_before", s_tvalid, 0);
    for (int k = 0; k < 3; k++) begin
      step(2'd0, 2'd0, 1'b0);
      check("bp_hold_tvalid", s_tvalid, 1);
      check("bp_hold_tdata",  s_tdata,  8'h5A);
      check("bp_hold_tlast",  s_tlast,  0);
    end
    send_bits(1, 1'b1);
    step(2'd0, 2'd0, 1'b1);
    check("bp_done_latency", s_done, 1);
    check("bp_no_overrun", s_ovr, 0);
    idle(2, 1'b1);
    check("bp_beats_left", exp_q.size(), 0);

    // Overrun: two byte completions with tready low
    pl = '{8'hE1, 8'hE2, 8'hE3};
    push_frame_bits(pl, 8, 1'b0);
    send_bits(1, 1'b0, 40);
    bit_q.delete();
    step(2'd0, 2'd0, 1'b0);
    exp_err++;
    check("ovr_flag",   s_ovr,    1);
    check("ovr_err",    s_err,    1);
    check("ovr_tvalid", s_tvalid, 1);
    check("ovr_tdata",  s_tdata,  8'hE1);
    step(2'd0, 2'd0, 1'b0);
    check("ovr_err_pulse", s_err, 0);
    check("ovr_tdata_held", s_tdata, 8'hE1);
    exp_q.push_back('{data: 8'hE1, last: 1'b0});
    step(2'd0, 2'd0, 1'b1);
    step(2'd0, 2'd0, 1'b1);
    check("ovr_drained", s_tvalid, 0);
    check("ovr_sticky", s_ovr, 1);
    check("ovr_err_count", err_seen, exp_err);
    check("ovr_done_count", done_seen, exp_done);

    // Idle timeout mid-payload, then a clean frame
    pl = '{8'h10, 8'h20, 8'h30};
    push_frame_bits(pl, 8, 1'b0);
    exp_q.push_back('{data: 8'h10, last: 1'b0});
    send_bits(1, 1'b1, 36);
    bit_q.delete();
    repeat (7) step(2'd0, 2'd0, 1'b1);
    step(2'd0, 2'd0, 1'b1);
    check("to_no_early_err", s_err, 0);
    step(2'd0, 2'd0, 1'b1);
    check("to_err", s_err, 1);
    exp_err++;
    pl = '{8'h77, 8'h88};
    queue_frame(pl, 8);
    send_bits(0, 1'b1);
    idle(3, 1'b1);
    check("to_recover_beats", exp_q.size(), 0);
    check("to_done_count", done_seen, exp_done);
    check("to_err_count",  err_seen,  exp_err);

    // num=3 injected mid-byte is ignored
    pl = '{8'h96};
    queue_frame(pl, 8);
    send_bits(1, 1'b1, 28);
    step(2'd3, 2'b11, 1'b1);
    step(2'd3, 2'b10, 1'b1);
    send_bits(1, 1'b1);
    step(2'd0, 2'd0, 1'b1);
    check("num3_done_latency", s_done, 1);
    idle(2, 1'b1);
    check("num3_beats_left", exp_q.size(), 0);

`ifdef MANCHESTER_DEFRAMER_CRC_EN
    // Corrupted CRC byte aborts after the payload is delivered
    pl = '{8'h01, 8'h02};
    push_frame_bits(pl, 8, 1'b1);
    exp_q.push_back('{data: 8'h01, last: 1'b0});
    exp_q.push_back('{data: 8'h02, last: 1'b1});
    exp_err++;
    send_bits(1, 1'b1);
    step(2'd0, 2'd0, 1'b1);
    check("crc_bad_err", s_err, 1);
    check("crc_bad_no_done", s_done, 0);
    idle(2, 1'b1);
`endif

    // Randomized frames and bit grouping
    for (int f = 0; f < 20; f++) begin
      len = int'($urandom_range(8, 1));
      pl.delete();
      repeat (len) pl.push_back(8'($urandom));
      queue_frame(pl, 8);
      send_bits(0, 1'b1);
    end
    idle(3, 1'b1);
    check("rand_beats_left", exp_q.size(), 0);
    check("rand_done_count", done_seen, exp_done);
    check("rand_err_count",  err_seen,  exp_err);

    // Asynchronous reset mid-payload with a byte pending
    pl = '{8'hC7, 8'hD8};
    push_frame_bits(pl, 8, 1'b0);
    send_bits(1, 1'b0, 32);
    step(2'd0, 2'd0, 1'b0);
    check("pre_rst_tvalid", s_tvalid, 1);
    #2 aresetn = 1'b0;
    #1;
    check("mid_rst_tvalid", m_axis_tvalid, 0);
    check("mid_rst_tdata",  m_axis_tdata,  0);
    check("mid_rst_tlast",  m_axis_tlast,  0);
    check("mid_rst_ovr",    overrun,       0);
    check("mid_rst_done",   frame_done,    0);
    check("mid_rst_err",    frame_err,     0);
    bit_q.delete();
    step(2'd0, 2'd0, 1'b1);
    aresetn = 1'b1;
    pl = '{8'h42};
    queue_frame(pl, 8);
    send_bits(2, 1'b1);
    idle(3, 1'b1);
    check("post_rst_beats_left", exp_q.size(), 0);
    check("final_done_count", done_seen, exp_done);
    check("final_err_count",  err_seen,  exp_err);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
